phase_det_5bit: RTL and testbench

PHASE_DET_5BIT -- requirements
Module: phase_det_5bit

---
 rtl/adpll_pkg.sv | 17 +
 rtl/phase_det_5bit_if.sv | 23 ++
 rtl/edge_sync.sv | 38 +++
 rtl/phase_det_5bit.sv | 164 ++++++++++++++++
 tb/tb_phase_det_5bit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL phase detector: FSM states, error width and limits.
package adpll_pkg;

  localparam int unsigned ERR_W       = 5;
  localparam int unsigned SYNC_STAGES = 2;

  typedef logic [ERR_W-1:0] err_t;

  localparam err_t ERR_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    DCO_LEAD = 2'd2
  } pd_state_e;

endpackage

// File: rtl/phase_det_5bit_if.sv
// Signal bundle between a phase-detector user (master) and the detector (slave).
interface phase_det_5bit_if;
  import adpll_pkg::*;

  logic ref_in;
  logic dco_in;
  err_t lock_thresh;
  err_t ctrl;
  logic ctrl_sign;
  logic err_valid;
  logic locked;

  modport master (
    output ref_in, dco_in, lock_thresh,
    input  ctrl, ctrl_sign, err_valid, locked
  );

  modport slave (
    input  ref_in, dco_in, lock_thresh,
    output ctrl, ctrl_sign, err_valid, locked
  );

endinterface

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous clock input into clk and flags each rising edge for one cycle.
module edge_sync
  import adpll_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o
);

  localparam int unsigned MSB = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] live_q;
  logic                   prev_q;
  logic                   armed_q;

  // live_q tracks which sync stages hold real samples; edges are only accepted once a
  // genuine low has been seen, so a level already high at reset release is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      live_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      live_q <= {live_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_q[MSB];
      if (live_q[MSB] && !sync_q[MSB]) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise_o = sync_q[MSB] & ~prev_q & armed_q;

endmodule

// File: rtl/phase_det_5bit.sv
// Bang-bang/linear phase detector: measures ref-to-dco edge spacing in clk cycles,
// reports a saturated 5-bit magnitude with sign, and tracks lock.
module phase_det_5bit
  import adpll_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ref_in,
  input  logic dco_in,
  input  err_t lock_thresh,
  output err_t ctrl,
  output logic ctrl_sign,
  output logic err_valid,
  output logic locked
);

  localparam int unsigned      LK_W     = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);
  localparam logic [LK_W-1:0]  LK_MAX   = LK_W'(LOCK_CNT);

  logic ref_rise;
  logic dco_rise;

  pd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   elapsed;
  err_t             meas_mag;
  logic             timeout;

  logic             issue_d;
  err_t             mag_d;
  logic             sign_d;

  err_t             ctrl_q;
  logic             sign_q;
  logic             valid_q;
  logic [LK_W-1:0]  lock_q, lock_d;

  edge_sync u_ref_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (ref_in),
    .rise_o (ref_rise)
  );

  edge_sync u_dco_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (dco_in),
    .rise_o (dco_rise)
  );

  // The counter is cleared on the leading edge, so the lagging edge N cycles later sees N-1.
  // Timeout fires on the cycle the counter would reach its maximum.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign elapsed  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign meas_mag = (elapsed > (CNT_W+1)'(ERR_MAX)) ? ERR_MAX : elapsed[ERR_W-1:0];
  assign timeout  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ref_rise && !dco_rise) begin
          state_d = REF_LEAD;
          cnt_d   = '0;
        end else if (dco_rise && !ref_rise) begin
          state_d = DCO_LEAD;
          cnt_d   = '0;
        end
      end
      REF_LEAD: begin
        if (dco_rise)      state_d = IDLE;
        else if (ref_rise) cnt_d   = '0;
        else if (timeout)  state_d = IDLE;
        else               cnt_d   = cnt_inc;
      end
      DCO_LEAD: begin
        if (ref_rise)      state_d = IDLE;
        else if (dco_rise) cnt_d   = '0;
        else if (timeout)  state_d = IDLE;
        else               cnt_d   = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_d = 1'b0;
    mag_d   = '0;
    sign_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ref_rise && dco_rise) issue_d = 1'b1;
      end
      REF_LEAD: begin
        if (dco_rise) begin
          issue_d = 1'b1;
          mag_d   = meas_mag;
        end else if (ref_rise || timeout) begin
          issue_d = 1'b1;
          mag_d   = ERR_MAX;
        end
      end
      DCO_LEAD: begin
        sign_d = 1'b1;
        if (ref_rise) begin
          issue_d = 1'b1;
          mag_d   = meas_mag;
        end else if (dco_rise || timeout) begin
          issue_d = 1'b1;
          mag_d   = ERR_MAX;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    lock_d = lock_q;
    if (issue_d) begin
      if (mag_d <= lock_thresh) lock_d = (lock_q == LK_MAX) ? lock_q : lock_q + LK_W'(1);
      else                      lock_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
      lock_q  <= '0;
    end else begin
      valid_q <= issue_d;
      lock_q  <= lock_d;
      if (issue_d) begin
        ctrl_q <= mag_d;
        sign_q <= sign_d;
      end
    end
  end

  assign ctrl      = ctrl_q;
  assign ctrl_sign = sign_q;
  assign err_valid = valid_q;
  assign locked    = (lock_q == LK_MAX);

endmodule

// File: tb/tb_phase_det_5bit.sv
// Self-checking bench for phase_det_5bit: randomized edge pairs scored against a gap-based model.
module tb_phase_det_5bit;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LOCK_CNT = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  phase_det_5bit_if pif ();

  phase_det_5bit #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ref_in     (pif.ref_in),
    .dco_in     (pif.dco_in),
    .lock_thresh(pif.lock_thresh),
    .ctrl       (pif.ctrl),
    .ctrl_sign  (pif.ctrl_sign),
    .err_valid  (pif.err_valid),
    .locked     (pif.locked)
  );

  typedef struct {
    int unsigned cyc;
    logic [4:0]  mag;
    logic        sgn;
    logic        lk;
  } rpt_t;

  rpt_t        rq[$];
  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pif.err_valid === 1'b1) rq.push_back('{cyc, pif.ctrl, pif.ctrl_sign, pif.locked});
  end

  // Reference: error magnitude is the raw edge spacing clipped to 31; sign says dco led.
  function automatic int unsigned model_mag(input int unsigned gap);
    return (gap > 31) ? 31 : gap;
  endfunction

  function automatic logic model_sign(input int unsigned gap, input bit ref_first);
    return (gap != 0) && !ref_first;
  endfunction

  task automatic drive_pair(input int unsigned gap, input bit ref_first);
    @(negedge clk);
    if (gap == 0) begin
      pif.ref_in = 1'b1;
      pif.dco_in = 1'b1;
    end else begin
      if (ref_first) pif.ref_in = 1'b1; else pif.dco_in = 1'b1;
      repeat (gap) @(negedge clk);
      if (ref_first) pif.dco_in = 1'b1; else pif.ref_in = 1'b1;
    end
    repeat (4) @(negedge clk);
    pif.ref_in = 1'b0;
    pif.dco_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_report(input int unsigned limit, output bit got, output rpt_t r);
    got = 1'b0;
    r   = '{0, 5'd0, 1'b0, 1'b0};
    for (int unsigned i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      #1;
      if (rq.size() > 0) begin
        r   = rq.pop_front();
        got = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    rq.delete();
  endtask

  task automatic test_reset();
    pif.ref_in      = 1'b0;
    pif.dco_in      = 1'b0;
    pif.lock_thresh = 5'd31;
    reset_n         = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (pif.ctrl !== 5'd0) $display("FAIL reset_ctrl: got %0d expected 0", pif.ctrl); else n_pass++;
    n_checks++; if (pif.ctrl_sign !== 1'b0) $display("FAIL reset_sign: got %0b expected 0", pif.ctrl_sign); else n_pass++;
    n_checks++; if (pif.err_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", pif.err_valid); else n_pass++;
    n_checks++; if (pif.locked !== 1'b0) $display("FAIL reset_locked: got %0b expected 0", pif.locked); else n_pass++;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    n_checks++; if (rq.size() != 0) $display("FAIL reset_quiet: got %0d reports expected 0", rq.size()); else n_pass++;
    rq.delete();
  endtask

  task automatic test_directed();
    int unsigned gaps[3] = '{7, 40, 0};
    bit          reff[3] = '{1'b1, 1'b0, 1'b1};
    rpt_t r;
    bit   got;
    for (int unsigned i = 0; i < 3; i++) begin
      drive_pair(gaps[i], reff[i]);
      wait_report(12, got, r);
      n_checks++;
      if (!got) $display("FAIL dir%0d_valid: got no err_valid expected one pulse", i);
      else begin
        n_pass++;
        n_checks++;
        if (r.mag !== 5'(model_mag(gaps[i])))
          $display("FAIL dir%0d_ctrl: got %0d expected %0d", i, r.mag, model_mag(gaps[i]));
        else n_pass++;
        n_checks++;
        if (r.sgn !== model_sign(gaps[i], reff[i]))
          $display("FAIL dir%0d_sign: got %0b expected %0b", i, r.sgn, model_sign(gaps[i], reff[i]));
        else n_pass++;
      end
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (rq.size() != 0) $display("FAIL dir%0d_single: got %0d extra pulses expected 0", i, rq.size());
      else n_pass++;
      rq.delete();
    end
  endtask

  task automatic test_random();
    rpt_t        r;
    bit          got;
    int unsigned gap;
    bit          ref_first;
    for (int unsigned i = 0; i < 10; i++) begin
      gap       = $urandom_range(45, 0);
      ref_first = 1'($urandom_range(1, 0));
      drive_pair(gap, ref_first);
      wait_report(12, got, r);
      n_checks++;
      if (!got) $display("FAIL rnd%0d_valid: got no err_valid expected one pulse (gap %0d)", i, gap);
      else begin
        n_pass++;
        n_checks++;
        if (r.mag !== 5'(model_mag(gap)) || r.sgn !== model_sign(gap, ref_first))
          $display("FAIL rnd%0d_err: got %0d/%0b expected %0d/%0b (gap %0d ref_first %0b)",
                   i, r.mag, r.sgn, model_mag(gap), model_sign(gap, ref_first), gap, ref_first);
        else n_pass++;
      end
      n_checks++;
      if (rq.size() != 0) $display("FAIL rnd%0d_single: got %0d extra pulses expected 0", i, rq.size());
      else n_pass++;
      rq.delete();
    end
  endtask

  task automatic test_slip_timeout();
    rpt_t        r1, r2;
    bit          got1, got2;
    int unsigned exp_gap = (1 << CNT_W) - 1;
    @(negedge clk);
    pif.ref_in = 1'b1;
    repeat (5) @(negedge clk);
    pif.ref_in = 1'b0;
    repeat (15) @(negedge clk);
    pif.ref_in = 1'b1;
    repeat (5) @(negedge clk);
    pif.ref_in = 1'b0;
    wait_report(20, got1, r1);
    n_checks++;
    if (!got1) $display("FAIL slip_valid: got no err_valid expected slip report");
    else begin
      n_pass++;
      n_checks++;
      if (r1.mag !== 5'd31 || r1.sgn !== 1'b0)
        $display("FAIL slip_err: got %0d/%0b expected 31/0", r1.mag, r1.sgn);
      else n_pass++;
    end
    wait_report(300, got2, r2);
    n_checks++;
    if (!got2) $display("FAIL timeout_valid: got no err_valid expected timeout report");
    else begin
      n_pass++;
      n_checks++;
      if (r2.mag !== 5'd31 || r2.sgn !== 1'b0)
        $display("FAIL timeout_err: got %0d/%0b expected 31/0", r2.mag, r2.sgn);
      else n_pass++;
      n_checks++;
      if (got1 && (r2.cyc - r1.cyc) != exp_gap)
        $display("FAIL timeout_gap: got %0d cycles expected %0d", r2.cyc - r1.cyc, exp_gap);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    rq.delete();
  endtask

  task automatic test_lock();
    int unsigned errs[8] = '{1, 2, 0, 1, 5, 0, 0, 0};
    int unsigned lk = 0;
    int unsigned thr = 2;
    rpt_t r;
    bit   got;
    bit   ref_first;
    do_reset();
    pif.lock_thresh = 5'(thr);
    for (int unsigned i = 5; i < 8; i++) errs[i] = $urandom_range(4, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      ref_first = 1'($urandom_range(1, 0));
      drive_pair(errs[i], ref_first);
      lk = (errs[i] <= thr) ? ((lk < LOCK_CNT) ? lk + 1 : LOCK_CNT) : 0;
      wait_report(12, got, r);
      n_checks++;
      if (!got) $display("FAIL lock%0d_valid: got no err_valid expected one pulse", i);
      else begin
        n_pass++;
        n_checks++;
        if (r.lk !== (lk == LOCK_CNT))
          $display("FAIL lock%0d_locked: got %0b expected %0b (err %0d)", i, r.lk, (lk == LOCK_CNT), errs[i]);
        else n_pass++;
      end
      rq.delete();
    end
  endtask

  task automatic test_reset_mid();
    rpt_t r;
    bit   got;
    pif.lock_thresh = 5'd31;
    drive_pair(9, 1'b0);
    wait_report(12, got, r);
    n_checks++;
    if (!got || r.mag !== 5'd9 || r.sgn !== 1'b1)
      $display("FAIL pre_reset_err: got %0b %0d/%0b expected 1 9/1", got, r.mag, r.sgn);
    else n_pass++;
    @(negedge clk);
    pif.ref_in = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pif.ctrl !== 5'd0 || pif.ctrl_sign !== 1'b0 || pif.err_valid !== 1'b0 || pif.locked !== 1'b0)
      $display("FAIL midreset_outputs: got %0d/%0b/%0b/%0b expected 0/0/0/0",
               pif.ctrl, pif.ctrl_sign, pif.err_valid, pif.locked);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (rq.size() != 0) $display("FAIL midreset_discard: got %0d reports expected 0", rq.size());
    else n_pass++;
    rq.delete();
    pif.ref_in = 1'b0;
    repeat (4) @(negedge clk);
    drive_pair(4, 1'b1);
    wait_report(12, got, r);
    n_checks++;
    if (!got || r.mag !== 5'd4 || r.sgn !== 1'b0)
      $display("FAIL post_reset_err: got %0b %0d/%0b expected 1 4/0", got, r.mag, r.sgn);
    else n_pass++;
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_slip_timeout();
    test_lock();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
